lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory-access stage directly downstream of the execute ALU. It takes the ALU result as an effective address, plus the store operand and a memory opcode. It runs one transaction at a time on the data-memory port and returns an aligned, sign- or zero-extended load value, or a store completion, to writeback. Misaligned accesses and unanswered requests are reported as faults instead of reaching, or hanging, the bus.

## Interface
- TIMEOUT_CYCLES, 255: cycles in REQ without `dmem_ack` before a bus error; 0 disables the timeout.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  execute offers an access.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- alu_res  in  32  effective address.
- store_data  in  32  rs2 value, LSB-justified.
- mem_op  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word, 11 illegal→misaligned fault).
- rd  in  5  destination register.
- out_valid  out  1  response to writeback.
- out_ready  in  1  writeback consumes the response.
- out_we  out  1  register write enable; 1 only for a successful load.
- out_rd  out  5  captured rd.
- out_data  out  32  extended load data; 0 for stores and faults.
- out_misaligned  out  1  alignment or illegal-size fault.
- out_bus_err  out  1  timeout fault.
- dmem_req  out  1  request, held until ack.
- dmem_we  out  1  write request.
- dmem_addr  out  32  {alu_res[31:2],2'b00}.
- dmem_wmask  out  4  byte-lane enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  single-cycle completion; sampled only in REQ.
- dmem_rdata  in  32  valid in the ack cycle.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE with in_valid:
  - Capture address, op, rd, store_data.
  - If the access is misaligned → RESP with out_misaligned=1. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Otherwise → REQ.
- REQ: dmem_req=1. On dmem_ack → RESP. Loads latch the extracted data.
- REQ timeout: the wait counter is cleared on entry. If it reaches TIMEOUT_CYCLES with no ack → RESP with out_bus_err=1, out_we=0, and dmem_req drops.
- RESP: out_valid=1. When out_ready is high → IDLE.
- Store byte: wmask = 1<<addr[1:0], wdata = {4{sd[7:0]}}.
- Store half: wmask = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
- Store word: wmask = 1111, wdata = sd.
- Load byte: select lane addr[1:0]. Load half: select lane addr[1]. Sign-extend unless mem_op[2]=1. For word loads, mem_op[2] is ignored.
- Faults never assert dmem_req. Fault responses always have out_we=0 and out_data=0.

## Timing
- Reset (rst_n low at an edge): state IDLE; all outputs 0 except in_ready=1. The counter and captured fields clear.
- Reset mid-REQ or mid-RESP abandons the access: dmem_req is low from the reset edge on, and a late ack is ignored.
- Accept at edge N. dmem_req is registered and is high in cycle N+1.
- Ack in cycle N+1 gives out_valid in cycle N+2. Minimum load/store latency is 2 cycles, misaligned fault latency is 1.
- dmem_addr, dmem_we, dmem_wmask and dmem_wdata are stable for the whole time dmem_req=1.
- out_* are stable while out_valid && !out_ready.
- No new accept in the cycle RESP completes. in_ready rises the cycle after the handshake, so throughput is one access per ≥3 cycles.
- Ack in the same cycle the counter hits TIMEOUT_CYCLES: the ack wins and there is no bus error.

## Structure
- Shared package `lsu_pkg`: mem_op field positions and size codes (SZ_B, SZ_H, SZ_W), state enum, and the misalignment predicate as a function.
- Sub-module `lsu_load_align`, purely combinational: (rdata, addr[1:0], size, unsigned) → 32-bit extended value.
- Store lane/mask generation stays inline.

## Test plan
- Load byte signed at 0x1003: rdata 0x80FF_1234 → out_data 0xFFFF_FF80, out_we=1. Repeat with unsigned: → 0x0000_0080.
- Store half to 0x2002, sd 0xDEAD_BEEF → dmem_addr 0x2000, wmask 1100, wdata 0xBEEF_BEEF, out_we=0.
- Word load at 0x0006 → out_misaligned=1 one cycle after accept, dmem_req never high.
- TIMEOUT_CYCLES=4 with ack withheld → out_bus_err=1 after 4 REQ cycles, dmem_req low afterwards. Then ack in exactly the 4th cycle → normal completion.
- Hold out_ready=0 for 3 cycles in RESP → out_* unchanged and in_ready=0 throughout.
- rst_n low during REQ, then ack one cycle later → no out_valid and state IDLE. The next access behaves normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared mem_op encoding, FSM states and alignment predicate for the LSU
package lsu_pkg;
  localparam int OP_ST = 3;
  localparam int OP_UNS = 2;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_X || (size == SZ_H && a[0]) || (size == SZ_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed lane of a read word and sign/zero extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = 8'(rdata >> {addr, 3'b000});
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  assign data = size == SZ_B ? {{24{b[7] & ~uns}}, b}
              : size == SZ_H ? {{16{h[15] & ~uns}}, h}
              : rdata;
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: single-outstanding load/store stage with alignment and bus-timeout faults
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_res,
  input  logic [31:0] store_data,
  input  logic [3:0]  mem_op,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_misaligned,
  output logic        out_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_e state, state_n;
  logic [31:0] addr_q, sd_q, data_q, ld;
  logic [3:0] op_q, mask;
  logic [4:0] rd_q;
  logic mis_q, berr_q, timeout;
  logic [1:0] sz;
  logic [CW-1:0] cnt;
  assign sz = op_q[1:0];
  assign timeout = TIMEOUT_CYCLES != 0 && cnt + CW'(1) == CW'(TIMEOUT_CYCLES);
  lsu_load_align u_align (
    .rdata(dmem_rdata),
    .addr (addr_q[1:0]),
    .size (sz),
    .uns  (op_q[OP_UNS]),
    .data (ld)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = misaligned(mem_op[1:0], alu_res[1:0]) ? RESP : REQ;
      REQ: if (dmem_ack || timeout) state_n = RESP;
      RESP: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      sd_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      mis_q <= 1'b0;
      berr_q <= 1'b0;
      data_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        addr_q <= alu_res;
        sd_q <= store_data;
        op_q <= mem_op;
        rd_q <= rd;
        mis_q <= misaligned(mem_op[1:0], alu_res[1:0]);
        berr_q <= 1'b0;
        data_q <= '0;
        cnt <= '0;
      end
      if (state == REQ) begin
        cnt <= cnt + CW'(1);
        if (dmem_ack) data_q <= op_q[OP_ST] ? '0 : ld;
        else if (timeout) berr_q <= 1'b1;
      end
    end
  end
  assign mask = sz == SZ_B ? 4'b0001 << addr_q[1:0] : sz == SZ_H ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign in_ready = state == IDLE;
  assign out_valid = state == RESP;
  assign out_we = out_valid & ~op_q[OP_ST] & ~mis_q & ~berr_q;
  assign out_rd = out_valid ? rd_q : '0;
  assign out_data = out_valid ? data_q : '0;
  assign out_misaligned = out_valid & mis_q;
  assign out_bus_err = out_valid & berr_q;
  assign dmem_req = state == REQ;
  assign dmem_we = dmem_req & op_q[OP_ST];
  assign dmem_addr = dmem_req ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_wmask = dmem_we ? mask : '0;
  assign dmem_wdata = !dmem_we ? '0 : sz == SZ_B ? {4{sd_q[7:0]}} : sz == SZ_H ? {2{sd_q[15:0]}} : sd_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage with a short bus timeout
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, dmem_ack = 1'b0;
  logic [31:0] alu_res = '0, store_data = '0, dmem_rdata = '0;
  logic [3:0] mem_op = '0;
  logic [4:0] rd = '0;
  logic in_ready, out_valid, out_we, out_misaligned, out_bus_err, dmem_req, dmem_we;
  logic [4:0] out_rd;
  logic [31:0] out_data, dmem_addr, dmem_wdata;
  logic [3:0] dmem_wmask;
  int n = 0;
  int fails = 0;
  always #5 clk = ~clk;
  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .store_data(store_data), .mem_op(mem_op), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_rd(out_rd),
    .out_data(out_data), .out_misaligned(out_misaligned), .out_bus_err(out_bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    in_valid = 1'b1;
    mem_op = op;
    alu_res = a;
    store_data = sd;
    rd = r;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic ack(input logic [31:0] data);
    dmem_ack = 1'b1;
    dmem_rdata = data;
    tick();
    dmem_ack = 1'b0;
  endtask
  task automatic finish_resp();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_resp", {in_ready, out_valid}, 32'b10);
  endtask
  initial begin
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_out_data", out_data, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    rst_n = 1'b1;
    tick();
    issue(4'b0000, 32'h1003, 32'h0, 5'd5);
    check("lb_req", dmem_req, 1);
    check("lb_addr", dmem_addr, 32'h1000);
    check("lb_we", dmem_we, 0);
    check("lb_in_ready", in_ready, 0);
    ack(32'h80FF_1234);
    check("lb_valid", out_valid, 1);
    check("lb_data", out_data, 32'hFFFF_FF80);
    check("lb_we_out", out_we, 1);
    check("lb_rd", out_rd, 5);
    check("lb_req_drop", dmem_req, 0);
    finish_resp();
    issue(4'b0100, 32'h1003, 32'h0, 5'd6);
    ack(32'h80FF_1234);
    check("lbu_data", out_data, 32'h0000_0080);
    check("lbu_we", out_we, 1);
    finish_resp();
    issue(4'b1001, 32'h2002, 32'hDEAD_BEEF, 5'd7);
    check("sh_addr", dmem_addr, 32'h2000);
    check("sh_mask", dmem_wmask, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh_we", dmem_we, 1);
    ack(32'h0);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_we", out_we, 0);
      check("hold_data", out_data, 0);
      check("hold_rd", out_rd, 7);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    finish_resp();
    issue(4'b0010, 32'h0006, 32'h0, 5'd8);
    check("mis_flag", out_misaligned, 1);
    check("mis_valid", out_valid, 1);
    check("mis_req", dmem_req, 0);
    check("mis_we", out_we, 0);
    check("mis_data", out_data, 0);
    finish_resp();
    issue(4'b0010, 32'h0010, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", dmem_req, 1);
      tick();
    end
    check("to_bus_err", out_bus_err, 1);
    check("to_valid", out_valid, 1);
    check("to_req_low", dmem_req, 0);
    check("to_we", out_we, 0);
    check("to_data", out_data, 0);
    finish_resp();
    issue(4'b0010, 32'h0010, 32'h0, 5'd10);
    tick();
    tick();
    tick();
    check("late_req", dmem_req, 1);
    ack(32'h1234_5678);
    check("late_bus_err", out_bus_err, 0);
    check("late_data", out_data, 32'h1234_5678);
    check("late_we", out_we, 1);
    finish_resp();
    issue(4'b0010, 32'h0020, 32'h0, 5'd11);
    rst_n = 1'b0;
    tick();
    check("rreq_req", dmem_req, 0);
    check("rreq_in_ready", in_ready, 1);
    rst_n = 1'b1;
    ack(32'hFFFF_FFFF);
    check("rreq_valid", out_valid, 0);
    check("rreq_idle", in_ready, 1);
    issue(4'b0101, 32'h3002, 32'h0, 5'd12);
    ack(32'hABCD_0000);
    check("lhu_data", out_data, 32'h0000_ABCD);
    check("lhu_rd", out_rd, 12);
    finish_resp();
    issue(4'b0001, 32'h3000, 32'h0, 5'd13);
    ack(32'h0000_8001);
    check("lh_data", out_data, 32'hFFFF_8001);
    finish_resp();
    issue(4'b1000, 32'h4001, 32'h1122_3344, 5'd14);
    check("sb_mask", dmem_wmask, 4'b0010);
    check("sb_wdata", dmem_wdata, 32'h4444_4444);
    ack(32'h0);
    check("sb_we", out_we, 0);
    finish_resp();
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
